// File: rtl/vx_mem_perf_mon_pkg.sv
// Shared types and helpers for the memory performance monitor slice.
package vx_mem_perf_mon_pkg;

   localparam int PERF_CTR_BITS = 44;

   // Aggregated per-port counters collected at the core level.
   typedef struct packed {
      logic [PERF_CTR_BITS-1:0] reads;
      logic [PERF_CTR_BITS-1:0] writes;
      logic [PERF_CTR_BITS-1:0] rsps;
      logic [PERF_CTR_BITS-1:0] latency;
   } mem_perf_t;

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) n = n + {31'd0, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/vx_mem_perf_mon_if.sv
// Per-lane request/response handshake bundle observed by the perf monitor.
interface vx_mem_perf_mon_if #(
   parameter int NUM_CHANNELS = 4
);
   logic [NUM_CHANNELS-1:0] req_fire;
   logic [NUM_CHANNELS-1:0] req_rw;
   logic [NUM_CHANNELS-1:0] rsp_fire;

   modport master (output req_fire, req_rw, rsp_fire);
   modport slave  (input  req_fire, req_rw, rsp_fire);
endinterface

// File: rtl/vx_perf_sat_acc.sv
// Clearable, enableable accumulator that either saturates at all-ones or wraps.
module vx_perf_sat_acc #(
   parameter int WIDTH     = 44,
   parameter int INC_WIDTH = 3,
   parameter int SATURATE  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [INC_WIDTH-1:0] inc,
   output logic [WIDTH-1:0]     value
);

   localparam int SUM_W = ((WIDTH > INC_WIDTH) ? WIDTH : INC_WIDTH) + 1;

   function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                input logic [INC_WIDTH-1:0] b);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(a) + SUM_W'(b);
      if ((SATURATE != 0) && (sum[SUM_W-1:WIDTH] != '0)) return '1;
      return sum[WIDTH-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (reset || clear) value <= '0;
      else if (enable)    value <= sat_add(value, inc);
   end

endmodule

// File: rtl/vx_mem_perf_mon.sv
// Multi-lane memory perf monitor: request/response counts, outstanding reads,
// accumulated read latency and peak outstanding.
module vx_mem_perf_mon
   import vx_mem_perf_mon_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int CTR_WIDTH    = 44,
   parameter int PEND_WIDTH   = 16,
   parameter int REQ_DELAY    = 1,
   parameter int SATURATE     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_i,
   input  logic                  freeze_i,
   vx_mem_perf_mon_if.slave      mem_if,
   output logic [CTR_WIDTH-1:0]  reads_o,
   output logic [CTR_WIDTH-1:0]  writes_o,
   output logic [CTR_WIDTH-1:0]  rsps_o,
   output logic [CTR_WIDTH-1:0]  latency_o,
   output logic [PEND_WIDTH-1:0] pending_o,
   output logic [PEND_WIDTH-1:0] peak_o,
   output logic                  underflow_o
);

   localparam int CNT_W = $clog2(NUM_CHANNELS + 1);
   localparam int SUM_W = PEND_WIDTH + 2;

   logic [NUM_CHANNELS-1:0] rd_vec, wr_vec;
   logic [CNT_W-1:0]        rd_n, wr_n, rsp_n;

   // p0 -> p1: optional request register stage, zeroed by reset so that
   // fires seen during reset are never injected afterwards.
   if (REQ_DELAY != 0) begin : g_req_dly
      logic [NUM_CHANNELS-1:0] req_fire_p1, req_rw_p1;
      always_ff @(posedge clk) begin
         if (reset) begin
            req_fire_p1 <= '0;
            req_rw_p1   <= '0;
         end else begin
            req_fire_p1 <= mem_if.req_fire;
            req_rw_p1   <= mem_if.req_rw;
         end
      end
      assign rd_vec = req_fire_p1 & ~req_rw_p1;
      assign wr_vec = req_fire_p1 &  req_rw_p1;
   end else begin : g_req_now
      assign rd_vec = mem_if.req_fire & ~mem_if.req_rw;
      assign wr_vec = mem_if.req_fire &  mem_if.req_rw;
   end

   assign rd_n  = CNT_W'(popcount(32'(rd_vec)));
   assign wr_n  = CNT_W'(popcount(32'(wr_vec)));
   assign rsp_n = CNT_W'(popcount(32'(mem_if.rsp_fire)));

   logic signed [SUM_W-1:0] pend_sum;
   logic [PEND_WIDTH-1:0]   pending_nxt;
   logic                    pend_under;

   assign pend_sum = $signed({2'b00, pending_o}) + $signed(SUM_W'(rd_n))
                   - $signed(SUM_W'(rsp_n));

   always_comb begin
      pend_under  = 1'b0;
      pending_nxt = pend_sum[PEND_WIDTH-1:0];
      if (pend_sum[SUM_W-1]) begin
         pend_under  = 1'b1;
         pending_nxt = '0;
      end else if (pend_sum[PEND_WIDTH]) begin
         pending_nxt = '1;
      end
   end

   // p1 -> outputs: pending keeps tracking through clear/freeze.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_o   <= '0;
         peak_o      <= '0;
         underflow_o <= 1'b0;
      end else begin
         pending_o <= pending_nxt;
         if (clear_i) begin
            peak_o      <= '0;
            underflow_o <= 1'b0;
         end else begin
            if (pend_under) underflow_o <= 1'b1;
            if (!freeze_i && (pending_nxt > peak_o)) peak_o <= pending_nxt;
         end
      end
   end

   vx_perf_sat_acc #(.WIDTH(CTR_WIDTH), .INC_WIDTH(CNT_W), .SATURATE(SATURATE)) u_reads (
      .clk(clk), .reset(reset), .clear(clear_i), .enable(!freeze_i), .inc(rd_n), .value(reads_o));

   vx_perf_sat_acc #(.WIDTH(CTR_WIDTH), .INC_WIDTH(CNT_W), .SATURATE(SATURATE)) u_writes (
      .clk(clk), .reset(reset), .clear(clear_i), .enable(!freeze_i), .inc(wr_n), .value(writes_o));

   vx_perf_sat_acc #(.WIDTH(CTR_WIDTH), .INC_WIDTH(CNT_W), .SATURATE(SATURATE)) u_rsps (
      .clk(clk), .reset(reset), .clear(clear_i), .enable(!freeze_i), .inc(rsp_n), .value(rsps_o));

   // Latency integrates the pre-update outstanding count each cycle.
   vx_perf_sat_acc #(.WIDTH(CTR_WIDTH), .INC_WIDTH(PEND_WIDTH), .SATURATE(SATURATE)) u_latency (
      .clk(clk), .reset(reset), .clear(clear_i), .enable(!freeze_i), .inc(pending_o), .value(latency_o));

endmodule

// File: tb/tb_vx_mem_perf_mon.sv
// Bench for vx_mem_perf_mon: vector table, corner sequences and a random run
// against a totals-based reference model; also covers 4-bit saturating/wrapping variants.
module tb_vx_mem_perf_mon;

   logic clk, reset, clear_i, freeze_i;
   int   n_cmp = 0;
   int   n_bad = 0;

   vx_mem_perf_mon_if #(.NUM_CHANNELS(4)) bus ();

   logic [43:0] m_reads, m_writes, m_rsps, m_lat;
   logic [15:0] m_pend, m_peak;
   logic        m_uf;
   logic [3:0]  s_reads, s_writes, s_rsps, s_lat, w_reads, w_writes, w_rsps, w_lat;
   logic [15:0] s_pend, s_peak, w_pend, w_peak;
   logic        s_uf, w_uf;

   vx_mem_perf_mon #(.NUM_CHANNELS(4), .CTR_WIDTH(44), .PEND_WIDTH(16), .REQ_DELAY(1), .SATURATE(1)) dut (
      .clk(clk), .reset(reset), .clear_i(clear_i), .freeze_i(freeze_i), .mem_if(bus),
      .reads_o(m_reads), .writes_o(m_writes), .rsps_o(m_rsps), .latency_o(m_lat),
      .pending_o(m_pend), .peak_o(m_peak), .underflow_o(m_uf));

   vx_mem_perf_mon #(.NUM_CHANNELS(4), .CTR_WIDTH(4), .PEND_WIDTH(16), .REQ_DELAY(1), .SATURATE(1)) dut_sat (
      .clk(clk), .reset(reset), .clear_i(clear_i), .freeze_i(freeze_i), .mem_if(bus),
      .reads_o(s_reads), .writes_o(s_writes), .rsps_o(s_rsps), .latency_o(s_lat),
      .pending_o(s_pend), .peak_o(s_peak), .underflow_o(s_uf));

   vx_mem_perf_mon #(.NUM_CHANNELS(4), .CTR_WIDTH(4), .PEND_WIDTH(16), .REQ_DELAY(1), .SATURATE(0)) dut_wrap (
      .clk(clk), .reset(reset), .clear_i(clear_i), .freeze_i(freeze_i), .mem_if(bus),
      .reads_o(w_reads), .writes_o(w_writes), .rsps_o(w_rsps), .latency_o(w_lat),
      .pending_o(w_pend), .peak_o(w_peak), .underflow_o(w_uf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference: true event totals since the last clear/reset; each DUT
   // variant's expected counter is derived from the total by clamp or modulo.
   longint unsigned r_rd, r_wr, r_rsp, r_lat;
   int              r_pend, r_peak;
   bit              r_uf;
   logic [3:0]      r_pf, r_prw;

   function automatic longint unsigned exp_ctr(longint unsigned tot, int w, bit sat);
      longint unsigned mx;
      mx = (64'd1 << w) - 64'd1;
      if (sat) return (tot > mx) ? mx : tot;
      return tot & mx;
   endfunction

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_update(input logic [3:0] f, rw, rs, input logic clr, frz, rst);
      int rd, wr, rp, np;
      bit under;
      if (rst) begin
         r_rd = 0; r_wr = 0; r_rsp = 0; r_lat = 0;
         r_pend = 0; r_peak = 0; r_uf = 0; r_pf = '0; r_prw = '0;
      end else begin
         rd = $countones(r_pf & ~r_prw);
         wr = $countones(r_pf & r_prw);
         rp = $countones(rs);
         np = r_pend + rd - rp;
         under = (np < 0);
         if (np < 0) np = 0;
         if (np > 65535) np = 65535;
         if (clr) begin
            r_rd = 0; r_wr = 0; r_rsp = 0; r_lat = 0; r_peak = 0; r_uf = 0;
         end else begin
            if (under) r_uf = 1;
            if (!frz) begin
               r_rd += longint'(rd); r_wr += longint'(wr); r_rsp += longint'(rp);
               r_lat += longint'(r_pend);
               if (np > r_peak) r_peak = np;
            end
         end
         r_pend = np;
         r_pf = f; r_prw = rw;
      end
   endtask

   task automatic check_model();
      chk("reads",     64'(m_reads),  exp_ctr(r_rd, 44, 1));
      chk("writes",    64'(m_writes), exp_ctr(r_wr, 44, 1));
      chk("rsps",      64'(m_rsps),   exp_ctr(r_rsp, 44, 1));
      chk("latency",   64'(m_lat),    exp_ctr(r_lat, 44, 1));
      chk("pending",   64'(m_pend),   64'(r_pend));
      chk("peak",      64'(m_peak),   64'(r_peak));
      chk("underflow", 64'(m_uf),     64'(r_uf));
      chk("sat_reads",   64'(s_reads),  exp_ctr(r_rd, 4, 1));
      chk("sat_writes",  64'(s_writes), exp_ctr(r_wr, 4, 1));
      chk("sat_rsps",    64'(s_rsps),   exp_ctr(r_rsp, 4, 1));
      chk("sat_latency", 64'(s_lat),    exp_ctr(r_lat, 4, 1));
      chk("sat_pending", 64'(s_pend),   64'(r_pend));
      chk("sat_peak",    64'(s_peak),   64'(r_peak));
      chk("sat_uf",      64'(s_uf),     64'(r_uf));
      chk("wrap_reads",   64'(w_reads),  exp_ctr(r_rd, 4, 0));
      chk("wrap_writes",  64'(w_writes), exp_ctr(r_wr, 4, 0));
      chk("wrap_rsps",    64'(w_rsps),   exp_ctr(r_rsp, 4, 0));
      chk("wrap_latency", 64'(w_lat),    exp_ctr(r_lat, 4, 0));
      chk("wrap_pending", 64'(w_pend),   64'(r_pend));
      chk("wrap_peak",    64'(w_peak),   64'(r_peak));
      chk("wrap_uf",      64'(w_uf),     64'(r_uf));
   endtask

   task automatic step(input logic [3:0] f, rw, rs, input logic clr, frz, rst);
      bus.req_fire = f; bus.req_rw = rw; bus.rsp_fire = rs;
      clear_i = clr; freeze_i = frz; reset = rst;
      @(posedge clk);
      model_update(f, rw, rs, clr, frz, rst);
      #1;
      check_model();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
   endtask

   typedef struct {
      logic [3:0] f, rw, rs;
      logic       clr, frz;
      int         rd, wr, rsps, pend, lat, peak;
      logic       uf;
   } vec_t;

   vec_t tbl [10];

   initial begin
      tbl[0] = '{4'b1111, 4'b0011, 4'b0000, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0};
      tbl[1] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2, 2, 0, 2, 0, 2, 1'b0};
      tbl[2] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2, 2, 0, 2, 2, 2, 1'b0};
      tbl[3] = '{4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 2, 2, 1, 1, 4, 2, 1'b0};
      tbl[4] = '{4'b0000, 4'b0000, 4'b0011, 1'b0, 1'b0, 2, 2, 3, 0, 5, 2, 1'b1};
      tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2, 2, 3, 0, 5, 2, 1'b1};
      tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0};
      tbl[7] = '{4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0};
      tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 0, 0, 0, 2, 0, 0, 1'b0};
      tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 0, 0, 2, 2, 2, 1'b0};

      bus.req_fire = '0; bus.req_rw = '0; bus.rsp_fire = '0;
      clear_i = 1'b0; freeze_i = 1'b0; reset = 1'b1;
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
      chk("reset_reads",   64'(m_reads), 64'd0);
      chk("reset_pending", 64'(m_pend),  64'd0);
      chk("reset_uf",      64'(m_uf),    64'd0);

      // Vector table: mixed read/write burst, drain with underflow, clear, freeze.
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].f, tbl[i].rw, tbl[i].rs, tbl[i].clr, tbl[i].frz, 1'b0);
         chk($sformatf("tbl%0d_reads", i),   64'(m_reads),  64'(tbl[i].rd));
         chk($sformatf("tbl%0d_writes", i),  64'(m_writes), 64'(tbl[i].wr));
         chk($sformatf("tbl%0d_rsps", i),    64'(m_rsps),   64'(tbl[i].rsps));
         chk($sformatf("tbl%0d_pending", i), 64'(m_pend),   64'(tbl[i].pend));
         chk($sformatf("tbl%0d_latency", i), 64'(m_lat),    64'(tbl[i].lat));
         chk($sformatf("tbl%0d_peak", i),    64'(m_peak),   64'(tbl[i].peak));
         chk($sformatf("tbl%0d_uf", i),      64'(m_uf),     64'(tbl[i].uf));
      end

      // Three reads answered six cycles later: five cycles at three outstanding.
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
      step(4'b0111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      idle(5);
      step(4'b0000, 4'b0000, 4'b0111, 1'b0, 1'b0, 1'b0);
      chk("lat15_latency", 64'(m_lat),  64'd15);
      chk("lat15_pending", 64'(m_pend), 64'd0);
      chk("lat15_peak",    64'(m_peak), 64'd3);
      chk("lat15_uf",      64'(m_uf),   64'd0);

      // Lone response with nothing outstanding: sticky underflow until clear.
      step(4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
      idle(3);
      chk("uf_sticky",  64'(m_uf),   64'd1);
      chk("uf_pending", 64'(m_pend), 64'd0);
      step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      chk("uf_cleared", 64'(m_uf), 64'd0);

      // Sixteen single-lane reads into 4-bit counters.
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) step(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      idle(1);
      chk("sat4_reads",  64'(s_reads), 64'd15);
      chk("wrap4_reads", 64'(w_reads), 64'd0);
      chk("main_reads16", 64'(m_reads), 64'd16);
      idle(2);
      chk("sat4_hold", 64'(s_reads), 64'd15);

      // Freeze with pending=5, two more reads, then clear.
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
      step(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      step(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      idle(1);
      chk("frz_pre_pending", 64'(m_pend), 64'd5);
      step(4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
      chk("frz_reads",   64'(m_reads), 64'd5);
      chk("frz_pending", 64'(m_pend),  64'd7);
      chk("frz_peak",    64'(m_peak),  64'd5);
      step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      chk("clr_reads",   64'(m_reads), 64'd0);
      chk("clr_pending", 64'(m_pend),  64'd7);
      idle(1);
      chk("clr_peak",    64'(m_peak),  64'd7);

      // Reset mid-traffic with pending=4 and fires active.
      step(4'b0000, 4'b0000, 4'b0011, 1'b0, 1'b0, 1'b0);
      idle(1);
      chk("rst_pre_pending", 64'(m_pend), 64'd5);
      step(4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
      chk("rst_pre_pending4", 64'(m_pend), 64'd4);
      step(4'b1111, 4'b0101, 4'b0011, 1'b0, 1'b0, 1'b1);
      chk("rst_reads",   64'(m_reads), 64'd0);
      chk("rst_writes",  64'(m_writes), 64'd0);
      chk("rst_pending", 64'(m_pend),  64'd0);
      chk("rst_latency", 64'(m_lat),   64'd0);
      idle(2);
      chk("rst_no_inject_reads",   64'(m_reads), 64'd0);
      chk("rst_no_inject_pending", 64'(m_pend),  64'd0);

      // Random traffic with occasional clear, freeze and reset.
      for (int i = 0; i < 3000; i++) begin
         step(4'($urandom), 4'($urandom), 4'($urandom & $urandom),
              ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 499) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
